// File: rtl/brew_pkg.sv
// Shared types for the drink sequencer: FSM state codes, drink codes, timer width.
package brew_pkg;

  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRIND = 3'd1,
    S_BREW  = 3'd2,
    S_MILK  = 3'd3,
    S_FROTH = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    D_NONE = 2'd0,
    D_ESP  = 2'd1,
    D_LAT  = 2'd2,
    D_CAP  = 2'd3
  } drink_e;

  // Simultaneous orders resolve capp > latte > espresso.
  function automatic drink_e pick_drink(input logic esp, input logic lat, input logic cap);
    if (cap)      return D_CAP;
    else if (lat) return D_LAT;
    else if (esp) return D_ESP;
    return D_NONE;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter: load T-1 on phase entry; expired is high on the phase's last cycle.
module phase_timer
  import brew_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expired
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/brew_sequencer.sv
// Drink sequencer FSM: grind/brew/milk/froth phases per drink type, overrun and count tracking.
module brew_sequencer
  import brew_pkg::*;
#(
  parameter int T_GRIND = 4,
  parameter int T_BREW  = 6,
  parameter int T_MILK  = 3,
  parameter int T_FROTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_espresso,
  input  logic       req_latte,
  input  logic       req_capp,
  input  logic       abort,
  input  logic       clr_ovr,
  output logic       grinder_on,
  output logic       pump_on,
  output logic       milk_on,
  output logic       froth_on,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic [7:0] drink_count,
  output logic [2:0] current_state
);

  localparam logic [TMR_W-1:0] LD_GRIND = TMR_W'(T_GRIND - 1);
  localparam logic [TMR_W-1:0] LD_BREW  = TMR_W'(T_BREW  - 1);
  localparam logic [TMR_W-1:0] LD_MILK  = TMR_W'(T_MILK  - 1);
  localparam logic [TMR_W-1:0] LD_FROTH = TMR_W'(T_FROTH - 1);

  state_e           state_q, state_d;
  drink_e           drink_q, drink_d;
  logic             ovr_q, ovr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_exp;
  logic             any_req;

  assign any_req = req_espresso | req_latte | req_capp;

  phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    drink_d  = drink_q;
    ovr_d    = ovr_q;
    cnt_d    = cnt_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    // Orders outside IDLE (DONE included) are dropped and flagged; set beats clear.
    if (clr_ovr)                        ovr_d = 1'b0;
    if (any_req && state_q != S_IDLE)   ovr_d = 1'b1;

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      drink_d = D_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req && !abort) begin
            drink_d  = pick_drink(req_espresso, req_latte, req_capp);
            state_d  = S_GRIND;
            tmr_load = 1'b1;
            tmr_val  = LD_GRIND;
          end
        end
        S_GRIND: begin
          if (tmr_exp) begin
            state_d  = S_BREW;
            tmr_load = 1'b1;
            tmr_val  = LD_BREW;
          end
        end
        S_BREW: begin
          if (tmr_exp) begin
            if (drink_q == D_ESP) begin
              state_d = S_DONE;
            end else begin
              state_d  = S_MILK;
              tmr_load = 1'b1;
              tmr_val  = LD_MILK;
            end
          end
        end
        S_MILK: begin
          if (tmr_exp) begin
            if (drink_q == D_CAP) begin
              state_d  = S_FROTH;
              tmr_load = 1'b1;
              tmr_val  = LD_FROTH;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_FROTH: begin
          if (tmr_exp) state_d = S_DONE;
        end
        S_DONE: begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_IDLE;
          drink_d = D_NONE;
        end
        default: begin
          state_d = S_IDLE;
          drink_d = D_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      drink_q <= D_NONE;
      ovr_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      drink_q <= drink_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore outputs straight off the async-reset state flop, so reset kills them at once.
  assign grinder_on    = (state_q == S_GRIND);
  assign pump_on       = (state_q == S_BREW);
  assign milk_on       = (state_q == S_MILK);
  assign froth_on      = (state_q == S_FROTH);
  assign done          = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign overrun       = ovr_q;
  assign drink_count   = cnt_q;
  assign current_state = state_q;

endmodule
